// File: rtl/fb_scanout.sv
// Upscaling frame-buffer scanout: 2-cycle buffer read, 4-cycle pixel pipeline, vsync-aligned swap.
// Optional clear-behind-read of the front buffer is built when FB_SCANOUT_CLEAR_EN is defined.
module fb_scanout #(
   parameter int FB_WIDTH    = 320,
   parameter int FB_HEIGHT   = 180,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        ad_in,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        swap_req_in,
   output logic        swap_ack_out,
   output logic        front_sel_out,
   output logic [15:0] rd_addr_out,
   input  logic [15:0] rd_data0_in,
   input  logic [15:0] rd_data1_in,
   output logic        clr_we_out,
   output logic [15:0] clr_addr_out,
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic        hs_out,
   output logic        vs_out,
   output logic        ad_out
);

   localparam logic [10:0] SCAN_W = 11'(FB_WIDTH << SCALE_SHIFT);
   localparam logic [9:0]  SCAN_H = 10'(FB_HEIGHT << SCALE_SHIFT);
   localparam logic [31:0] FB_W32 = 32'(FB_WIDTH);

   typedef enum logic [1:0] {WAIT_FRAME, SCAN, VBLANK} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        pending_q, pending_d;
   logic        front_sel_q, front_sel_d;
   logic        swap_ack_q, swap_ack_d;
   logic [15:0] rd_addr_q, rd_addr_d;
   logic [2:0]  pix_vld_q, pix_vld_d;
   logic [2:0]  pix_sel_q, pix_sel_d;
   logic [3:0]  hs_pipe_q, hs_pipe_d;
   logic [3:0]  vs_pipe_q, vs_pipe_d;
   logic [3:0]  ad_pipe_q, ad_pipe_d;
   logic [7:0]  red_q, red_d;
   logic [7:0]  green_q, green_d;
   logic [7:0]  blue_q, blue_d;

   logic        frame_start, frame_end, swap_now;
   logic        addr_en, pix_vld;
   logic [15:0] rd_dat;

   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   assign frame_end   = (hcount_in == 11'd0) && (vcount_in == SCAN_H);
   assign swap_now    = (state_q == SCAN) && frame_end && (pending_q || swap_req_in);

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_FRAME: if (frame_start) state_d = SCAN;
         SCAN:       if (frame_end)   state_d = VBLANK;
         VBLANK:     if (frame_start) state_d = SCAN;
         default:    state_d = WAIT_FRAME;
      endcase
   end

   // The cycle that enters SCAN already addresses pixel (0,0), so qualify on the next state.
   assign addr_en = (state_d == SCAN) && (hcount_in < SCAN_W);
   assign pix_vld = addr_en && (vcount_in < SCAN_H);

   always_comb begin
      req_d       = swap_req_in;
      front_sel_d = front_sel_q ^ swap_now;
      swap_ack_d  = swap_now;
      if (swap_now)
         pending_d = 1'b0;
      else
         pending_d = pending_q | (swap_req_in & ~req_q);
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (addr_en)
         rd_addr_d = 16'((32'(vcount_in >> SCALE_SHIFT) * FB_W32) + 32'(hcount_in >> SCALE_SHIFT));
      pix_vld_d = {pix_vld_q[1:0], pix_vld};
      pix_sel_d = {pix_sel_q[1:0], front_sel_q};
      hs_pipe_d = {hs_pipe_q[2:0], hs_in};
      vs_pipe_d = {vs_pipe_q[2:0], vs_in};
      ad_pipe_d = {ad_pipe_q[2:0], ad_in};
   end

   // Buffer select travels with the address so a swap cannot split a pixel.
   assign rd_dat = pix_sel_q[2] ? rd_data1_in : rd_data0_in;

   always_comb begin
      red_d   = 8'd0;
      green_d = 8'd0;
      blue_d  = 8'd0;
      if (pix_vld_q[2]) begin
         red_d   = {rd_dat[15:11], 3'b000};
         green_d = {rd_dat[10:5],  2'b00};
         blue_d  = {rd_dat[4:0],   3'b000};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= WAIT_FRAME;
         req_q       <= 1'b0;
         pending_q   <= 1'b0;
         front_sel_q <= 1'b0;
         swap_ack_q  <= 1'b0;
         rd_addr_q   <= 16'd0;
         pix_vld_q   <= 3'd0;
         pix_sel_q   <= 3'd0;
         hs_pipe_q   <= 4'd0;
         vs_pipe_q   <= 4'd0;
         ad_pipe_q   <= 4'd0;
         red_q       <= 8'd0;
         green_q     <= 8'd0;
         blue_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         pending_q   <= pending_d;
         front_sel_q <= front_sel_d;
         swap_ack_q  <= swap_ack_d;
         rd_addr_q   <= rd_addr_d;
         pix_vld_q   <= pix_vld_d;
         pix_sel_q   <= pix_sel_d;
         hs_pipe_q   <= hs_pipe_d;
         vs_pipe_q   <= vs_pipe_d;
         ad_pipe_q   <= ad_pipe_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
      end
   end

   assign swap_ack_out  = swap_ack_q;
   assign front_sel_out = front_sel_q;
   assign rd_addr_out   = rd_addr_q;
   assign red_out       = red_q;
   assign green_out     = green_q;
   assign blue_out      = blue_q;
   assign hs_out        = hs_pipe_q[3];
   assign vs_out        = vs_pipe_q[3];
   assign ad_out        = ad_pipe_q[3];

`ifdef FB_SCANOUT_CLEAR_EN
   // Clear only on the last of the scaled reads of a texel, once its data has been captured.
   logic        clr_cand;
   logic [3:0]  clr_pipe_q, clr_pipe_d;
   logic [15:0] clr_a1_q, clr_a1_d;
   logic [15:0] clr_a2_q, clr_a2_d;
   logic [15:0] clr_addr_q, clr_addr_d;

   assign clr_cand = pix_vld && (&hcount_in[SCALE_SHIFT-1:0]) && (&vcount_in[SCALE_SHIFT-1:0]);

   always_comb begin
      clr_pipe_d = {clr_pipe_q[2:0], clr_cand};
      clr_a1_d   = rd_addr_q;
      clr_a2_d   = clr_a1_q;
      clr_addr_d = clr_a2_q;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         clr_pipe_q <= 4'd0;
         clr_a1_q   <= 16'd0;
         clr_a2_q   <= 16'd0;
         clr_addr_q <= 16'd0;
      end else begin
         clr_pipe_q <= clr_pipe_d;
         clr_a1_q   <= clr_a1_d;
         clr_a2_q   <= clr_a2_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign clr_we_out   = clr_pipe_q[3];
   assign clr_addr_out = clr_addr_q;
`else
   assign clr_we_out   = 1'b0;
   assign clr_addr_out = 16'd0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: vector table plus hand sequences for swap, clear and reset corners.
module tb_fb_scanout;

`ifdef FB_SCANOUT_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        ad_in, hs_in, vs_in, swap_req_in;
   logic        swap_ack_out, front_sel_out;
   logic [15:0] rd_addr_out, rd_data0_in, rd_data1_in;
   logic        clr_we_out;
   logic [15:0] clr_addr_out;
   logic [7:0]  red_out, green_out, blue_out;
   logic        hs_out, vs_out, ad_out;

   always #5 clk_in = ~clk_in;

   fb_scanout dut (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .ad_in(ad_in), .hs_in(hs_in), .vs_in(vs_in), .swap_req_in(swap_req_in),
      .swap_ack_out(swap_ack_out), .front_sel_out(front_sel_out), .rd_addr_out(rd_addr_out),
      .rd_data0_in(rd_data0_in), .rd_data1_in(rd_data1_in), .clr_we_out(clr_we_out),
      .clr_addr_out(clr_addr_out), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out)
   );

   int errors = 0;
   int checks = 0;

   bit mon_en = 1'b0;
   bit seen [65536];
   int clr_cnt = 0;
   int clr_dup = 0;

   always @(negedge clk_in) begin
      if (mon_en && clr_we_out) begin
         clr_cnt++;
         if (seen[clr_addr_out]) clr_dup++;
         seen[clr_addr_out] = 1'b1;
      end
   end

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        ad;
      logic [23:0] rgb;
      logic [15:0] addr;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic pos(input int h, input int v);
      hcount_in = 11'(h);
      vcount_in = 10'(v);
   endtask

   initial begin
      int seen_cnt, seen_oob, cnt0;

      vecs[0] = '{11'd1279, 10'd719, 16'h07E0, 16'hF81F, 1'b1, 24'h00FC00, 16'd57599};
      vecs[1] = '{11'd4,    10'd4,   16'h001F, 16'hFFE0, 1'b0, 24'h0000F8, 16'd321};
      vecs[2] = '{11'd1280, 10'd4,   16'hFFFF, 16'hFFFF, 1'b1, 24'h000000, 16'd321};
      vecs[3] = '{11'd100,  10'd50,  16'hFFFF, 16'h0000, 1'b1, 24'hF8FCF8, 16'd3865};
      vecs[4] = '{11'd7,    10'd3,   16'hA5A5, 16'h5A5A, 1'b0, 24'hA0B428, 16'd1};
      vecs[5] = '{11'd1283, 10'd10,  16'hFFFF, 16'h0000, 1'b1, 24'h000000, 16'd1};

      // Reset with busy inputs
      rst_in = 1'b0; pos(100, 100);
      rd_data0_in = 16'hFFFF; rd_data1_in = 16'hFFFF;
      ad_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; swap_req_in = 1'b0;
      tick(3);
      chk("rst_rgb", {red_out, green_out, blue_out}, 0);
      chk("rst_sync", {hs_out, vs_out, ad_out}, 0);
      chk("rst_rd_addr", rd_addr_out, 0);
      chk("rst_ctl", {front_sel_out, swap_ack_out, clr_we_out}, 0);
      chk("rst_clr_addr", clr_addr_out, 0);

      // Released, but no frame start yet: stays black
      rst_in = 1'b1; ad_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
      tick(6);
      chk("wait_black", {red_out, green_out, blue_out}, 0);
      chk("wait_addr", rd_addr_out, 0);

      // First pixel, exact 4-cycle latency on RGB and hsync
      pos(0, 0); rd_data0_in = 16'hF800; rd_data1_in = 16'h0000; hs_in = 1'b1;
      tick(1);
      pos(1300, 0); hs_in = 1'b0;
      tick(2);
      chk("lat3_rgb", {red_out, green_out, blue_out}, 0);
      chk("lat3_hs", hs_out, 0);
      tick(1);
      chk("lat4_rgb", {red_out, green_out, blue_out}, 24'hF80000);
      chk("lat4_hs", hs_out, 1);
      tick(1);
      chk("lat5_rgb", {red_out, green_out, blue_out}, 0);
      chk("lat5_hs", hs_out, 0);

      for (int i = 0; i < 6; i++) begin
         pos(vecs[i].h, vecs[i].v);
         rd_data0_in = vecs[i].d0; rd_data1_in = vecs[i].d1; ad_in = vecs[i].ad;
         tick(4);
         chk($sformatf("vec%0d_rgb", i), {red_out, green_out, blue_out}, vecs[i].rgb);
         chk($sformatf("vec%0d_addr", i), rd_addr_out, vecs[i].addr);
         chk($sformatf("vec%0d_ad", i), ad_out, vecs[i].ad);
      end
      ad_in = 1'b0;

      // Clear timing: final read of texel 0, non-final read, final read of texel 1
      pos(3, 3); tick(1); pos(1300, 3); tick(2);
      chk("clr_t3", clr_we_out, 0);
      tick(1);
      chk("clr_t4_we", clr_we_out, CLR_EN);
      chk("clr_t4_addr", clr_addr_out, 0);
      tick(1);
      chk("clr_t5", clr_we_out, 0);
      pos(2, 3); tick(1); pos(1300, 3); tick(3);
      chk("clr_nonfinal", clr_we_out, 0);
      pos(7, 3); tick(1); pos(1300, 3); tick(3);
      chk("clr_texel1_we", clr_we_out, CLR_EN);
      chk("clr_texel1_addr", clr_addr_out, CLR_EN ? 32'd1 : 32'd0);

      // Two requests in one frame collapse into one swap
      pos(10, 10); swap_req_in = 1'b1; tick(1); swap_req_in = 1'b0; tick(2);
      pos(20, 10); swap_req_in = 1'b1; tick(1); swap_req_in = 1'b0; tick(1);
      chk("swap_pre", {front_sel_out, swap_ack_out}, 2'b00);
      pos(0, 720); tick(1);
      chk("swap1", {front_sel_out, swap_ack_out}, 2'b11);
      pos(1, 720); tick(1);
      chk("swap1_ack_end", {front_sel_out, swap_ack_out}, 2'b10);
      pos(0, 0); tick(1);
      pos(8, 8); rd_data0_in = 16'hF800; rd_data1_in = 16'h001F; tick(4);
      chk("front1_rgb", {red_out, green_out, blue_out}, 24'h0000F8);
      pos(0, 720); tick(1);
      chk("no_second_swap", {front_sel_out, swap_ack_out}, 2'b10);

      // Request in VBLANK waits for the next frame end
      pos(5, 730); swap_req_in = 1'b1; tick(1); swap_req_in = 1'b0; tick(1);
      chk("vbl_req_wait", {front_sel_out, swap_ack_out}, 2'b10);
      pos(0, 0); tick(1);
      chk("vbl_req_scan", {front_sel_out, swap_ack_out}, 2'b10);
      pos(50, 50); tick(2);
      pos(0, 720); tick(1);
      chk("vbl_req_swap", {front_sel_out, swap_ack_out}, 2'b01);
      pos(1, 720); tick(1);
      chk("vbl_req_ack_end", swap_ack_out, 0);

      // Request rising on the frame-end cycle itself
      pos(0, 0); tick(1); pos(50, 50); tick(2);
      pos(0, 720); swap_req_in = 1'b1; tick(1);
      chk("edge_swap", {front_sel_out, swap_ack_out}, 2'b11);
      swap_req_in = 1'b0; pos(1, 720); tick(1);
      chk("edge_ack_end", swap_ack_out, 0);
      pos(0, 0); tick(1); pos(50, 50); tick(2); pos(0, 720); tick(1);
      chk("edge_no_repeat", {front_sel_out, swap_ack_out}, 2'b10);

      // Full frame of final-read positions: every texel cleared once
      mon_en = 1'b1;
      pos(0, 0); tick(1);
      for (int by = 0; by < 180; by++)
         for (int bx = 0; bx < 320; bx++) begin
            pos(bx * 4 + 3, by * 4 + 3);
            tick(1);
         end
      pos(1300, 719); tick(5);
      pos(0, 720); tick(1);
      pos(7, 3); rd_data0_in = 16'hFFFF; rd_data1_in = 16'hFFFF; tick(4);
      chk("vblank_rgb", {red_out, green_out, blue_out}, 0);
      pos(3, 723); tick(5);
      seen_cnt = 0; seen_oob = 0;
      for (int a = 0; a < 65536; a++)
         if (seen[a]) begin
            if (a < 57600) seen_cnt++;
            else seen_oob++;
         end
      chk("frame_clr_count", clr_cnt, CLR_EN ? 32'd57600 : 32'd0);
      chk("frame_clr_dup", clr_dup, 0);
      chk("frame_clr_cover", seen_cnt, CLR_EN ? 32'd57600 : 32'd0);
      chk("frame_clr_oob", seen_oob, 0);
      chk("frame_front", front_sel_out, 1);

      // Reset in the middle of SCAN with a clear in flight
      cnt0 = clr_cnt;
      hs_in = 1'b1; vs_in = 1'b1; ad_in = 1'b1;
      pos(0, 0); tick(1); pos(10, 99); tick(4);
      pos(7, 99); tick(1);
      chk("pre_rst_rgb", {red_out, green_out, blue_out}, 24'hF8FCF8);
      pos(8, 100); rst_in = 1'b0;
      #1;
      chk("midrst_rgb", {red_out, green_out, blue_out}, 0);
      chk("midrst_sync", {hs_out, vs_out, ad_out}, 0);
      chk("midrst_addr", rd_addr_out, 0);
      chk("midrst_ctl", {front_sel_out, swap_ack_out, clr_we_out}, 0);
      tick(5);
      rst_in = 1'b1; pos(40, 100); tick(6);
      chk("postrst_black", {red_out, green_out, blue_out}, 0);
      chk("postrst_no_clr", clr_cnt, cnt0);
      pos(0, 0); tick(4);
      chk("postrst_first", {red_out, green_out, blue_out}, 24'hF8FCF8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter FB_WIDTH, 320, frame-buffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, 180, frame-buffer height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, 2, log2 of the upscale factor (320x180 to 1280x720).
REQ-004 SHALL have port clk_in  input  1  single system/pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports hcount_in  input  11 and vcount_in  input  10, the video timing position.
REQ-007 SHALL have ports ad_in, hs_in, vs_in  input  1 each, the timing active-draw, hsync and vsync.
REQ-008 SHALL have port swap_req_in  input  1  level: renderer finished the back buffer.
REQ-009 SHALL have port swap_ack_out  output  1  one-cycle pulse: swap performed.
REQ-010 SHALL have port front_sel_out  output  1  displayed buffer index; renderer writes the other.
REQ-011 SHALL have port rd_addr_out  output  16  read address to both buffers' port B.
REQ-012 SHALL have ports rd_data0_in and rd_data1_in  input  16 each, RGB565 port-B data of buffers 0 and 1.
REQ-013 SHALL have ports clr_we_out  output  1 and clr_addr_out  output  16, the clear-behind-read write to the front buffer (data 0).
REQ-014 SHALL have ports red_out, green_out, blue_out  output  8 each, plus hs_out, vs_out, ad_out  output  1 each.

Function
REQ-015 FSM states SHALL be WAIT_FRAME, SCAN and VBLANK.
REQ-016 WAIT_FRAME SHALL go to SCAN when hcount_in==0 and vcount_in==0.
REQ-017 SCAN SHALL go to VBLANK when hcount_in==0 and vcount_in==FB_HEIGHT<<SCALE_SHIFT.
REQ-018 VBLANK SHALL go to SCAN when hcount_in==0 and vcount_in==0.
REQ-019 In SCAN, when hcount_in<FB_WIDTH<<SCALE_SHIFT, rd_addr_out SHALL register (vcount_in>>SCALE_SHIFT)*FB_WIDTH + (hcount_in>>SCALE_SHIFT), max 57599; otherwise it SHALL hold.
REQ-020 Buffer read latency SHALL be 2 cycles; RGB SHALL be registered once more, giving 4 cycles from hcount_in/vcount_in to red/green/blue_out.
REQ-021 hs_out, vs_out and ad_out SHALL be hs_in, vs_in and ad_in delayed exactly 4 cycles.
REQ-022 Data SHALL be taken from rd_data{front_sel_out}_in and expanded as red={d[15:11],3'b0}, green={d[10:5],2'b0}, blue={d[4:0],3'b0}.
REQ-023 RGB SHALL be 0 for positions outside the scaled area, or when the FSM is not in SCAN at address time.
REQ-024 A rise of swap_req_in SHALL set a pending flag.
REQ-025 On the SCAN-to-VBLANK transition, if pending (or swap_req_in is high that cycle), front_sel_out SHALL toggle, swap_ack_out SHALL pulse one cycle, and pending SHALL clear.
REQ-026 A request arriving during VBLANK SHALL wait for the next SCAN-to-VBLANK transition.
REQ-027 Repeated requests before a swap SHALL collapse into one swap.
REQ-028 Clear-behind-read: clr_we_out SHALL assert for address A only on the final read of A, i.e. hcount_in[SCALE_SHIFT-1:0] and vcount_in[SCALE_SHIFT-1:0] all ones.
REQ-029 clr_addr_out SHALL equal that A, aligned to cycle 3 after the read address is issued (after data capture).
REQ-030 Every front-buffer pixel SHALL be cleared exactly once per SCAN frame, completing before VBLANK entry.
REQ-031 No clear write SHALL occur in WAIT_FRAME or VBLANK.

Reset
REQ-032 While rst_in==0, the FSM SHALL be in WAIT_FRAME, and front_sel_out, pending, swap_ack_out, clr_we_out, clr_addr_out, rd_addr_out, RGB and delayed syncs SHALL all be 0.
REQ-033 After deassertion, outputs SHALL remain black until the first hcount_in==0, vcount_in==0.
REQ-034 Reset mid-SCAN SHALL abort the frame immediately, with no further clear writes.

Configuration
REQ-035 With macro FB_SCANOUT_CLEAR_EN defined, clear-behind-read SHALL be implemented per REQ-028 to REQ-031.
REQ-036 Without FB_SCANOUT_CLEAR_EN, clr_we_out and clr_addr_out SHALL be tied 0 and no clear logic SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-037 Reset, then h=0,v=0 with rd_data0_in=16'hF800 -> after 4 cycles red_out=8'hF8, green_out=0, blue_out=0.
REQ-038 h=1279,v=719 -> rd_addr_out=57599; h=4,v=4 -> rd_addr_out=321; h=1280 -> RGB 0 and rd_addr_out held.
REQ-039 Pulse swap_req_in mid-SCAN -> at v=720,h=0 front_sel_out goes 0 to 1 with a one-cycle swap_ack_out; a second pulse in the same frame -> still one swap.
REQ-040 FB_SCANOUT_CLEAR_EN on, one full frame -> exactly 57600 clr_we_out pulses, each address once, first clr_addr_out=0 at h=3,v=3 (+3 cycles).
REQ-041 Drop rst_in at v=100 -> all outputs 0 immediately; after release, RGB stays black until v=0,h=0.
REQ-042 swap_req_in rising exactly at h=0,v=720 -> swap occurs in that cycle.
